// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, queue entry layout and PC helpers.
package cpu_fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fifo_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] alignPc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {instr, pc} queue between the fetch engine and decode; the head
// is presented combinationally and reads as zero while the queue is empty.
module fetch_fifo
   import cpu_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [INSTR_W-1:0]   pushInstr,
   input  logic [31:0]          pushPc,
   input  logic                 pop,
   input  logic                 clear,
   output logic                 headValid,
   output logic [INSTR_W-1:0]   headInstr,
   output logic [31:0]          headPc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DEPTH_I = DEPTH;

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             full;
   logic             doPush;
   logic             doPop;

   assign full      = (count == CNT_W'(DEPTH_I));
   assign headValid = (count != '0);
   assign doPush    = push && !full && !clear;
   assign doPop     = pop && headValid && !clear;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the storage array has no reset; an empty queue masks the head to zero,
   // so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= '{instr: pushInstr, pc: pushPc};
   end

   assign headInstr = headValid ? mem[rdPtr].instr : '0;
   assign headPc    = headValid ? mem[rdPtr].pc    : '0;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: credit-limited request stream into a small queue,
// redirect handling with in-flight response draining, and a sticky protocol flag.
module instr_prefetch
   import cpu_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   output logic        protocol_err
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int SUM_W   = CNT_W + 1;
   localparam int DEPTH_I = DEPTH;
   localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(DEPTH_I);

   fetch_state_t     state;
   logic [31:0]      fetchPc;
   logic [31:0]      respPc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] dropCnt;
   logic [CNT_W-1:0] fifoCount;
   logic             protocolErrQ;

   logic [31:0]      target;
   logic [SUM_W-1:0] inFlight;
   logic [CNT_W-1:0] redirectDrop;
   logic             respHit;
   logic             stray;
   logic             grant;
   logic             fifoPush;
   logic             fifoPop;

   // NOTE: every signal here is assigned on every path, so no latches are inferred.
   always_comb begin
      target       = alignPc(redirect_pc);
      respHit      = imem_rvalid && (outstanding != '0);
      stray        = imem_rvalid && (outstanding == '0) && (dropCnt == '0);
      inFlight     = {1'b0, fifoCount} + {1'b0, outstanding};
      imem_req     = (state == RUN) && !redirect && (inFlight < DEPTH_LIM);
      grant        = imem_req && imem_gnt;
      fifoPush     = (state == RUN) && !redirect && respHit;
      fifoPop      = if_valid && if_ready;
      // A response arriving in the redirect cycle is already accounted for here.
      redirectDrop = outstanding - CNT_W'(respHit);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= BOOT;
         fetchPc      <= RESET_PC;
         respPc       <= RESET_PC;
         outstanding  <= '0;
         dropCnt      <= '0;
         protocolErrQ <= 1'b0;
      end else begin
         if (stray) protocolErrQ <= 1'b1;

         case (state)
            BOOT: begin
               state <= RUN;
               if (redirect) begin
                  fetchPc <= target;
                  respPc  <= target;
               end
            end

            RUN: begin
               if (redirect) begin
                  fetchPc     <= target;
                  respPc      <= target;
                  outstanding <= '0;
                  dropCnt     <= redirectDrop;
                  state       <= (redirectDrop != '0) ? FLUSH : RUN;
               end else begin
                  if (grant)    fetchPc <= fetchPc + PC_INC;
                  if (fifoPush) respPc  <= respPc + PC_INC;
                  case ({grant, respHit})
                     2'b10:   outstanding <= outstanding + 1'b1;
                     2'b01:   outstanding <= outstanding - 1'b1;
                     default: ;
                  endcase
               end
            end

            FLUSH: begin
               if (redirect) begin
                  fetchPc <= target;
                  respPc  <= target;
               end
               // Stale responses are counted off and discarded until none remain.
               if (dropCnt == '0) begin
                  state <= RUN;
               end else if (imem_rvalid) begin
                  dropCnt <= dropCnt - 1'b1;
                  if (dropCnt == CNT_W'(1)) state <= RUN;
               end
            end

            default: state <= BOOT;
         endcase
      end
   end

   assign imem_addr    = fetchPc;
   assign protocol_err = protocolErrQ;

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifoPush),
      .pushInstr(imem_rdata),
      .pushPc   (respPc),
      .pop      (fifoPop),
      .clear    (redirect),
      .headValid(if_valid),
      .headInstr(if_instr),
      .headPc   (if_pc),
      .count    (fifoCount)
   );

endmodule
